// File: rtl/psum_acc_ctrl.sv
// Multi-pass partial-sum accumulator: loads pass 0 into psum memory, read-modify-writes
// later passes with saturating addition, then drains the N results downstream.
module psum_acc_ctrl #(
    parameter int unsigned PDATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH  = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    input  logic [ADDR_WIDTH:0]    i_num_psum,
    input  logic [7:0]             i_num_pass,
    input  logic                   i_psum_valid,
    input  logic [PDATA_WIDTH-1:0] i_psum_data,
    output logic                   o_psum_ready,
    output logic                   o_out_valid,
    output logic [PDATA_WIDTH-1:0] o_out_data,
    input  logic                   i_out_ready,
    output logic                   o_mem_rd_en,
    output logic [ADDR_WIDTH-1:0]  o_mem_rd_addr,
    input  logic [PDATA_WIDTH-1:0] i_mem_rd_data,
    output logic                   o_mem_wr_en,
    output logic [ADDR_WIDTH-1:0]  o_mem_wr_addr,
    output logic [PDATA_WIDTH-1:0] o_mem_wr_data,
    output logic                   o_busy,
    output logic                   o_done
);

    localparam int unsigned NW = ADDR_WIDTH + 1;

    typedef enum logic [2:0] {
        StIdle, StLoad, StAccRd, StAccWr, StDrRd, StDrCap, StDrOut, StDone
    } state_e;

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  k_q, k_d;
    logic [7:0]             pass_q, pass_d;
    logic [NW-1:0]          n_q, n_d;
    logic [7:0]             p_q, p_d;
    logic [PDATA_WIDTH-1:0] hold_q, hold_d;
    logic [PDATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                   out_valid_q, out_valid_d;

    logic                   psum_ready;
    logic                   psum_hs;
    logic                   k_last;
    logic [PDATA_WIDTH:0]   sum_ext;
    logic [PDATA_WIDTH-1:0] sat_sum;

    assign psum_ready = (state_q == StLoad) || (state_q == StAccRd);
    assign psum_hs    = psum_ready && i_psum_valid;
    assign k_last     = ({1'b0, k_q} == (n_q - NW'(1)));

    // One extra bit of headroom; overflow shows up as the top two bits disagreeing.
    always_comb begin
        sum_ext = {hold_q[PDATA_WIDTH-1], hold_q}
                + {i_mem_rd_data[PDATA_WIDTH-1], i_mem_rd_data};
        if (sum_ext[PDATA_WIDTH] != sum_ext[PDATA_WIDTH-1]) begin
            sat_sum = sum_ext[PDATA_WIDTH] ? {1'b1, {(PDATA_WIDTH-1){1'b0}}}
                                           : {1'b0, {(PDATA_WIDTH-1){1'b1}}};
        end else begin
            sat_sum = sum_ext[PDATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= StIdle;
            k_q         <= '0;
            pass_q      <= '0;
            n_q         <= '0;
            p_q         <= '0;
            hold_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            pass_q      <= pass_d;
            n_q         <= n_d;
            p_q         <= p_d;
            hold_q      <= hold_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        pass_d      = pass_q;
        n_d         = n_q;
        p_d         = p_q;
        hold_d      = hold_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    n_d    = i_num_psum;
                    p_d    = i_num_pass;
                    k_d    = '0;
                    pass_d = '0;
                    state_d = (i_num_psum == '0 || i_num_pass == '0) ? StDone : StLoad;
                end
            end
            StLoad: begin
                if (psum_hs) begin
                    if (k_last) begin
                        k_d     = '0;
                        pass_d  = 8'd1;
                        state_d = (p_q > 8'd1) ? StAccRd : StDrRd;
                    end else begin
                        k_d = k_q + ADDR_WIDTH'(1);
                    end
                end
            end
            StAccRd: begin
                if (psum_hs) begin
                    hold_d  = i_psum_data;
                    state_d = StAccWr;
                end
            end
            StAccWr: begin
                if (k_last) begin
                    k_d     = '0;
                    pass_d  = pass_q + 8'd1;
                    state_d = ((pass_q + 8'd1) == p_q) ? StDrRd : StAccRd;
                end else begin
                    k_d     = k_q + ADDR_WIDTH'(1);
                    state_d = StAccRd;
                end
            end
            StDrRd: state_d = StDrCap;
            StDrCap: begin
                out_data_d  = i_mem_rd_data;
                out_valid_d = 1'b1;
                state_d     = StDrOut;
            end
            StDrOut: begin
                if (i_out_ready) begin
                    out_valid_d = 1'b0;
                    if (k_last) begin
                        state_d = StDone;
                    end else begin
                        k_d     = k_q + ADDR_WIDTH'(1);
                        state_d = StDrRd;
                    end
                end
            end
            StDone: begin
                k_d     = '0;
                pass_d  = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        o_psum_ready  = psum_ready;
        o_out_valid   = out_valid_q;
        o_out_data    = out_data_q;
        o_busy        = (state_q != StIdle);
        o_done        = (state_q == StDone);
        o_mem_rd_en   = 1'b0;
        o_mem_rd_addr = '0;
        o_mem_wr_en   = 1'b0;
        o_mem_wr_addr = '0;
        o_mem_wr_data = '0;
        unique case (state_q)
            StLoad: begin
                if (psum_hs) begin
                    o_mem_wr_en   = 1'b1;
                    o_mem_wr_addr = k_q;
                    o_mem_wr_data = i_psum_data;
                end
            end
            StAccRd, StDrRd: begin
                o_mem_rd_en   = 1'b1;
                o_mem_rd_addr = k_q;
            end
            StAccWr: begin
                o_mem_wr_en   = 1'b1;
                o_mem_wr_addr = k_q;
                o_mem_wr_data = sat_sum;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_psum_acc_ctrl.sv
// Randomized scoreboard bench for psum_acc_ctrl with a behavioural memory and accumulate model.
module tb_psum_acc_ctrl;

    localparam int W = 16;
    localparam int A = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [A:0]   num_psum = '0;
    logic [7:0]   num_pass = '0;
    logic         psum_valid = 1'b0;
    logic [W-1:0] psum_data = '0;
    logic         psum_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready = 1'b1;
    logic         mem_rd_en;
    logic [A-1:0] mem_rd_addr;
    logic [W-1:0] mem_rd_data = '0;
    logic         mem_wr_en;
    logic [A-1:0] mem_wr_addr;
    logic [W-1:0] mem_wr_data;
    logic         busy;
    logic         done;

    always #5 clk = ~clk;

    psum_acc_ctrl #(.PDATA_WIDTH(W), .ADDR_WIDTH(A)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_num_psum(num_psum),
        .i_num_pass(num_pass), .i_psum_valid(psum_valid), .i_psum_data(psum_data),
        .o_psum_ready(psum_ready), .o_out_valid(out_valid), .o_out_data(out_data),
        .i_out_ready(out_ready), .o_mem_rd_en(mem_rd_en), .o_mem_rd_addr(mem_rd_addr),
        .i_mem_rd_data(mem_rd_data), .o_mem_wr_en(mem_wr_en), .o_mem_wr_addr(mem_wr_addr),
        .o_mem_wr_data(mem_wr_data), .o_busy(busy), .o_done(done)
    );

    logic [W-1:0] mem [0:(1<<A)-1];
    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    end

    int n_checks = 0;
    int n_pass = 0;
    task automatic check(string name, longint act, longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    int exp_q[$];
    int cyc = 0, done_cyc = 0, done_cnt = 0, wr_cnt = 0, rd_cnt = 0, rdy_cnt = 0, viol = 0;
    int bp_mode = 0, stall = 0;
    bit rand_valid = 0;
    bit have_prev = 0;
    logic [W-1:0] prev_data;

    always @(posedge clk) cyc++;

    // Monitor: every output handshake pops the scoreboard; held outputs must stay stable.
    always @(negedge clk) begin
        if (!rst_n) begin
            have_prev = 0;
        end else begin
            if (mem_rd_en && mem_wr_en) viol++;
            if ((!busy || done) && (mem_rd_en || mem_wr_en)) viol++;
            if (mem_wr_en) wr_cnt++;
            if (mem_rd_en) rd_cnt++;
            if (psum_ready) rdy_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (out_valid) begin
                if (have_prev) check("out_stable", out_data, prev_data);
                if (out_ready) begin
                    if (exp_q.size() == 0) check("unexpected_out", exp_q.size(), 1);
                    else check("out_data", longint'($signed(out_data)), exp_q.pop_front());
                    have_prev = 0;
                end else begin
                    have_prev = 1;
                    prev_data = out_data;
                end
            end else begin
                have_prev = 0;
            end
        end
    end

    // Downstream ready: always, 5-cycle stall per result, or random.
    always begin
        @(posedge clk);
        #1;
        if (bp_mode == 0) out_ready = 1'b1;
        else if (bp_mode == 2) out_ready = 1'($urandom_range(0, 1));
        else if (out_valid) begin
            if (stall >= 5) out_ready = 1'b1;
            else begin
                out_ready = 1'b0;
                stall++;
            end
        end else begin
            out_ready = 1'b0;
            stall = 0;
        end
    end

    function automatic int sat(int x);
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    function automatic void model(int n, int p, int vals[$]);
        int acc[$];
        for (int i = 0; i < n; i++) acc.push_back(vals[i]);
        for (int ps = 1; ps < p; ps++)
            for (int i = 0; i < n; i++) acc[i] = sat(acc[i] + vals[ps*n + i]);
        for (int i = 0; i < n; i++) exp_q.push_back(acc[i]);
    endfunction

    task automatic pulse_start(int n, int p);
        start = 1'b1;
        num_psum = (A+1)'(n);
        num_pass = 8'(p);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic feed(int v);
        int waitc;
        if (rand_valid && $urandom_range(0, 1) == 1) begin
            psum_valid = 1'b0;
            repeat ($urandom_range(1, 3)) begin
                @(posedge clk);
                #1;
            end
        end
        psum_valid = 1'b1;
        psum_data = W'(v);
        waitc = 0;
        while (1) begin
            @(negedge clk);
            if (psum_ready) break;
            waitc++;
            if (waitc > 200) begin
                check("psum_timeout", waitc, 0);
                break;
            end
        end
        @(posedge clk);
        #1;
        psum_valid = 1'b0;
    endtask

    task automatic run_job(string name, int n, int p, int vals[$], int bp, bit rv,
                           bit extra_start, output int lat);
        int d0, w0, v0, c0, waitc;
        bp_mode = bp;
        rand_valid = rv;
        model(n, p, vals);
        d0 = done_cnt; w0 = wr_cnt; v0 = viol;
        pulse_start(n, p);
        c0 = cyc;
        for (int i = 0; i < n*p; i++) feed(vals[i]);
        if (extra_start) pulse_start(1, 1);
        waitc = 0;
        while (done_cnt == d0 && waitc < 3000) begin
            @(posedge clk);
            waitc++;
        end
        #1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        lat = done_cyc - c0;
        check({name, "_done_count"}, done_cnt - d0, 1);
        check({name, "_writes"}, wr_cnt - w0, n*p);
        check({name, "_enable_rules"}, viol - v0, 0);
        check({name, "_pending"}, exp_q.size(), 0);
        check({name, "_idle"}, busy, 0);
        exp_q.delete();
    endtask

    task automatic check_zero(string name);
        check({name, "_valid"}, out_valid, 0);
        check({name, "_data"}, out_data, 0);
        check({name, "_busy_done_ready"}, {busy, done, psum_ready}, 0);
        check({name, "_mem"}, {mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data}, 0);
    endtask

    initial begin
        int lat, d0, r0, rd0, w0, n, p;
        int v[$];

        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;
        repeat (2) begin @(posedge clk); #1; end

        v = '{1, 2, 3, 4};
        r0 = rd_cnt;
        run_job("n4p1", 4, 1, v, 0, 0, 0, lat);
        check("n4p1_latency_ok", (lat <= 17) ? 1 : 0, 1);
        check("n4p1_reads", rd_cnt - r0, 4);

        v = '{10, 20, 30, 1, 2, 3, -5, -5, -5};
        run_job("n3p3", 3, 3, v, 0, 0, 0, lat);
        run_job("n3p3_bp", 3, 3, v, 1, 1, 0, lat);

        v = '{30000, 10000};
        run_job("sat_pos", 1, 2, v, 0, 0, 0, lat);
        v = '{-30000, -10000};
        run_job("sat_neg", 1, 2, v, 1, 0, 0, lat);

        v = '{5, 6, 7, 8, 9, 10};
        run_job("busy_start", 3, 2, v, 0, 0, 1, lat);

        // Abort in the middle of a read-modify-write.
        bp_mode = 0; rand_valid = 0;
        d0 = done_cnt;
        pulse_start(3, 3);
        feed(10); feed(20); feed(30); feed(1);
        check("in_acc_wr", {mem_wr_en, psum_ready}, 2'b10);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_zero("mid_reset");
        rst_n = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        check("abort_no_done", done_cnt - d0, 0);
        v = '{7, 8};
        run_job("after_reset", 2, 1, v, 0, 0, 0, lat);

        // Degenerate starts go straight to completion.
        for (int z = 0; z < 2; z++) begin
            d0 = done_cnt; r0 = rdy_cnt; rd0 = rd_cnt; w0 = wr_cnt;
            pulse_start(z == 0 ? 0 : 4, z == 0 ? 3 : 0);
            @(negedge clk);
            check("zero_done_pulse", done, 1);
            @(negedge clk);
            check("zero_done_single", done, 0);
            @(posedge clk);
            #1;
            check("zero_no_ready", rdy_cnt - r0, 0);
            check("zero_no_mem", (rd_cnt - rd0) + (wr_cnt - w0), 0);
            check("zero_done_count", done_cnt - d0, 1);
        end

        for (int j = 0; j < 6; j++) begin
            n = $urandom_range(1, 6);
            p = $urandom_range(1, 4);
            v.delete();
            for (int i = 0; i < n*p; i++) v.push_back(int'($urandom_range(0, 65535)) - 32768);
            run_job("random", n, p, v, $urandom_range(0, 2), 1'($urandom_range(0, 1)), 0, lat);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
